jtopl_mmr_wr: RTL and testbench

//  CPU-side register write decoder feeding the operator/channel register file.

---
 rtl/jtopl_mmr_wr.sv | 161 ++++++++++++++++
 tb/tb_jtopl_mmr_wr.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/jtopl_mmr_wr.sv
// CPU-side register write decoder: latches the OPL address/data ports, decodes data writes
// into operator/channel strobes and captures the global timer/rhythm/CSM registers.
module jtopl_mmr_wr #(
  parameter int OPL_TYPE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cen,
  input  logic [7:0] din,
  input  logic       addr,
  input  logic       cs_n,
  input  logic       wr_n,
  output logic       write,
  output logic [7:0] dout,
  output logic [1:0] sel_group,
  output logic [2:0] sel_sub,
  output logic       up_mult,
  output logic       up_ksl_tl,
  output logic       up_ar_dr,
  output logic       up_sl_rr,
  output logic       up_wav,
  output logic       up_fnumlo,
  output logic       up_fnumhi,
  output logic       up_fbcon,
  output logic       wave_mode,
  output logic       csm,
  output logic       note_sel,
  output logic [7:0] value_A,
  output logic [7:0] value_B,
  output logic       load_A,
  output logic       load_B,
  output logic       flagen_A,
  output logic       flagen_B,
  output logic       clr_flag,
  output logic       am_dep,
  output logic       vib_dep,
  output logic       rhy_en,
  output logic [4:0] rhy_kon,
  output logic       busy
);

  localparam logic [4:0] SLOT_COUNT = 5'd18;

  logic       we, we_l, we_rise;
  logic [7:0] addr_q;
  logic [4:0] busy_cnt;

  // Strobe vector order: mult, ksl_tl, ar_dr, sl_rr, wav, fnumlo, fnumhi, fbcon
  logic [7:0] up_q, dec_up;
  logic [1:0] dec_group;
  logic [2:0] dec_sub;
  logic       op_ok, ch_ok;
  logic       data_wr;

  assign we      = ~cs_n & ~wr_n;
  assign we_rise = we & ~we_l;
  assign data_wr = we_rise & addr;

  assign op_ok = (addr_q[4:3] != 2'd3) && (addr_q[2:0] < 3'd6);
  assign ch_ok = addr_q[3:0] < 4'd9;

  // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
  always_comb begin
    dec_up    = '0;
    dec_group = addr_q[4:3];
    dec_sub   = addr_q[2:0];
    case (addr_q[7:5])
      3'd1: dec_up[7] = op_ok;
      3'd2: dec_up[6] = op_ok;
      3'd3: dec_up[5] = op_ok;
      3'd4: dec_up[4] = op_ok;
      3'd7: dec_up[3] = op_ok && (OPL_TYPE != 1);
      default: ;
    endcase
    case (addr_q[7:4])
      4'hA: dec_up[2] = ch_ok;
      4'hB: dec_up[1] = ch_ok;
      4'hC: dec_up[0] = ch_ok;
      default: ;
    endcase
    if (addr_q[7:4] inside {4'hA, 4'hB, 4'hC}) begin
      case (addr_q[3:0])
        4'd0, 4'd1, 4'd2: dec_group = 2'd0;
        4'd3, 4'd4, 4'd5: dec_group = 2'd1;
        default:          dec_group = 2'd2;
      endcase
      case (addr_q[3:0])
        4'd0, 4'd3, 4'd6: dec_sub = 3'd0;
        4'd1, 4'd4, 4'd7: dec_sub = 3'd1;
        default:          dec_sub = 3'd2;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_l      <= 1'b0;
      addr_q    <= 8'h00;
      write     <= 1'b0;
      dout      <= 8'h00;
      sel_group <= 2'd0;
      sel_sub   <= 3'd0;
      up_q      <= '0;
      wave_mode <= 1'b0;
      csm       <= 1'b0;
      note_sel  <= 1'b0;
      value_A   <= 8'h00;
      value_B   <= 8'h00;
      load_A    <= 1'b0;
      load_B    <= 1'b0;
      flagen_A  <= 1'b1;
      flagen_B  <= 1'b1;
      clr_flag  <= 1'b0;
      am_dep    <= 1'b0;
      vib_dep   <= 1'b0;
      rhy_en    <= 1'b0;
      rhy_kon   <= 5'd0;
      busy_cnt  <= 5'd0;
      busy      <= 1'b0;
    end else begin
      we_l     <= we;
      write    <= data_wr;
      clr_flag <= 1'b0;
      if (we_rise && !addr) addr_q <= din;
      if (data_wr) begin
        dout     <= din;
        up_q     <= dec_up;
        busy_cnt <= SLOT_COUNT;
        busy     <= 1'b1;
        if (dec_up != '0) begin
          sel_group <= dec_group;
          sel_sub   <= dec_sub;
        end
        case (addr_q)
          8'h01: wave_mode <= (OPL_TYPE != 1) & din[5];
          8'h02: value_A <= din;
          8'h03: value_B <= din;
          8'h04: begin
            if (din[7]) clr_flag <= 1'b1;
            else begin
              load_A   <= din[0];
              load_B   <= din[1];
              flagen_A <= ~din[6];
              flagen_B <= ~din[5];
            end
          end
          8'h08: {csm, note_sel} <= din[7:6];
          8'hBD: {am_dep, vib_dep, rhy_en, rhy_kon} <= din;
          default: ;
        endcase
      end else if (cen && busy_cnt != 5'd0) begin
        busy_cnt <= busy_cnt - 5'd1;
        busy     <= (busy_cnt != 5'd1);
      end
    end
  end

  assign {up_mult, up_ksl_tl, up_ar_dr, up_sl_rr, up_wav, up_fnumlo, up_fnumhi, up_fbcon} = up_q;

endmodule

// File: tb/tb_jtopl_mmr_wr.sv
// Directed bench for jtopl_mmr_wr: one OPL and one OPL2 instance share the same CPU bus.
module tb_jtopl_mmr_wr;

  logic       clk = 1'b0;
  logic       rst, cen, addr, cs_n, wr_n;
  logic [7:0] din;

  logic       write [2], wave_mode [2], csm [2], note_sel [2];
  logic [7:0] dout [2], value_A [2], value_B [2];
  logic [1:0] sel_group [2];
  logic [2:0] sel_sub [2];
  logic       up_mult [2], up_ksl_tl [2], up_ar_dr [2], up_sl_rr [2], up_wav [2];
  logic       up_fnumlo [2], up_fnumhi [2], up_fbcon [2];
  logic       load_A [2], load_B [2], flagen_A [2], flagen_B [2], clr_flag [2];
  logic       am_dep [2], vib_dep [2], rhy_en [2], busy [2];
  logic [4:0] rhy_kon [2];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    jtopl_mmr_wr #(.OPL_TYPE(g + 1)) dut (
      .clk(clk), .rst(rst), .cen(cen), .din(din), .addr(addr), .cs_n(cs_n), .wr_n(wr_n),
      .write(write[g]), .dout(dout[g]), .sel_group(sel_group[g]), .sel_sub(sel_sub[g]),
      .up_mult(up_mult[g]), .up_ksl_tl(up_ksl_tl[g]), .up_ar_dr(up_ar_dr[g]),
      .up_sl_rr(up_sl_rr[g]), .up_wav(up_wav[g]), .up_fnumlo(up_fnumlo[g]),
      .up_fnumhi(up_fnumhi[g]), .up_fbcon(up_fbcon[g]), .wave_mode(wave_mode[g]),
      .csm(csm[g]), .note_sel(note_sel[g]), .value_A(value_A[g]), .value_B(value_B[g]),
      .load_A(load_A[g]), .load_B(load_B[g]), .flagen_A(flagen_A[g]), .flagen_B(flagen_B[g]),
      .clr_flag(clr_flag[g]), .am_dep(am_dep[g]), .vib_dep(vib_dep[g]), .rhy_en(rhy_en[g]),
      .rhy_kon(rhy_kon[g]), .busy(busy[g])
    );
  end

  function automatic logic [7:0] up_vec(int i);
    return {up_mult[i], up_ksl_tl[i], up_ar_dr[i], up_sl_rr[i], up_wav[i],
            up_fnumlo[i], up_fnumhi[i], up_fbcon[i]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Asserts the bus and takes one edge; the write is accepted on that edge.
  task automatic pulse_we(input logic a, input logic [7:0] d);
    addr = a; din = d; cs_n = 1'b0; wr_n = 1'b0;
    tick();
  endtask

  task automatic idle();
    cs_n = 1'b1; wr_n = 1'b1;
    tick();
  endtask

  // Address write followed by a data write; returns right after the data edge.
  task automatic reg_wr(input logic [7:0] a, input logic [7:0] d);
    pulse_we(1'b0, a);
    idle();
    pulse_we(1'b1, d);
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] d;
    logic [7:0] up;
    logic [1:0] grp;
    logic [2:0] sub;
  } vec_t;

  vec_t vecs [13];
  int   npulse;

  initial begin
    vecs[0]  = '{8'h23, 8'h41, 8'h80, 2'd0, 3'd3};
    vecs[1]  = '{8'h2E, 8'h55, 8'h00, 2'd0, 3'd3};
    vecs[2]  = '{8'hB7, 8'h31, 8'h02, 2'd2, 3'd1};
    vecs[3]  = '{8'h48, 8'h12, 8'h40, 2'd1, 3'd0};
    vecs[4]  = '{8'h75, 8'h00, 8'h20, 2'd2, 3'd5};
    vecs[5]  = '{8'h96, 8'h07, 8'h00, 2'd2, 3'd5};
    vecs[6]  = '{8'h8D, 8'hAA, 8'h10, 2'd1, 3'd5};
    vecs[7]  = '{8'hA0, 8'h11, 8'h04, 2'd0, 3'd0};
    vecs[8]  = '{8'hC8, 8'h22, 8'h01, 2'd2, 3'd2};
    vecs[9]  = '{8'hA9, 8'h33, 8'h00, 2'd2, 3'd2};
    vecs[10] = '{8'h38, 8'h44, 8'h00, 2'd2, 3'd2};
    vecs[11] = '{8'hE1, 8'h05, 8'h00, 2'd2, 3'd2};
    vecs[12] = '{8'hBD, 8'hFF, 8'h00, 2'd2, 3'd2};

    rst = 1'b1; cen = 1'b0; addr = 1'b0; cs_n = 1'b1; wr_n = 1'b1; din = 8'h00;
    tick(); tick();
    rst = 1'b0;
    tick();

    check("reset_up", 32'(up_vec(0)), 32'h0);
    check("reset_busy", 32'(busy[0]), 32'd0);
    check("reset_flagen", 32'({flagen_A[0], flagen_B[0]}), 32'h3);
    check("reset_dout", 32'(dout[0]), 32'h0);

    pulse_we(1'b0, 8'h23);
    check("addr_no_write", 32'(write[0]), 32'd0);
    idle();
    check("addr_no_busy", 32'(busy[0]), 32'd0);

    foreach (vecs[i]) begin
      reg_wr(vecs[i].a, vecs[i].d);
      check($sformatf("v%0d_write", i), 32'(write[0]), 32'd1);
      check($sformatf("v%0d_up", i), 32'(up_vec(0)), 32'(vecs[i].up));
      check($sformatf("v%0d_sel", i), 32'({sel_group[0], sel_sub[0]}),
            32'({vecs[i].grp, vecs[i].sub}));
      check($sformatf("v%0d_dout", i), 32'(dout[0]), 32'(vecs[i].d));
      check($sformatf("v%0d_busy", i), 32'(busy[0]), 32'd1);
      idle();
      check($sformatf("v%0d_write_end", i), 32'(write[0]), 32'd0);
      check($sformatf("v%0d_up_held", i), 32'(up_vec(0)), 32'(vecs[i].up));
    end
    check("bd_regs", 32'({am_dep[0], vib_dep[0], rhy_en[0], rhy_kon[0]}), 32'hFF);

    reg_wr(8'h02, 8'h5A); idle();
    check("value_A", 32'(value_A[0]), 32'h5A);
    reg_wr(8'h03, 8'hC3); idle();
    check("value_B", 32'(value_B[0]), 32'hC3);
    reg_wr(8'h04, 8'h63);
    check("timer_ctl", 32'({load_A[0], load_B[0], flagen_A[0], flagen_B[0]}), 32'b1100);
    check("timer_clr_idle", 32'(clr_flag[0]), 32'd0);
    idle();
    reg_wr(8'h04, 8'h80);
    check("clr_flag_pulse", 32'(clr_flag[0]), 32'd1);
    check("clr_flag_no_up", 32'(up_vec(0)), 32'h0);
    check("clr_keeps_ctl", 32'({load_A[0], load_B[0], flagen_A[0], flagen_B[0]}), 32'b1100);
    idle();
    check("clr_flag_end", 32'(clr_flag[0]), 32'd0);
    reg_wr(8'h08, 8'hC0); idle();
    check("csm_note_sel", 32'({csm[0], note_sel[0]}), 32'b11);

    reg_wr(8'hE0, 8'h03);
    check("opl1_wav", 32'(up_wav[0]), 32'd0);
    check("opl2_wav", 32'(up_wav[1]), 32'd1);
    check("opl2_wav_sel", 32'({sel_group[1], sel_sub[1]}), 32'h0);
    idle();
    reg_wr(8'h01, 8'h20); idle();
    check("opl1_wave_mode", 32'(wave_mode[0]), 32'd0);
    check("opl2_wave_mode", 32'(wave_mode[1]), 32'd1);

    // busy counts exactly 18 cen after the data write
    reg_wr(8'h23, 8'h41); idle();
    for (int k = 0; k < 17; k++) begin
      cen = 1'b1; tick(); cen = 1'b0; tick();
    end
    check("busy_17_cen", 32'(busy[0]), 32'd1);
    cen = 1'b1; tick(); cen = 1'b0;
    check("busy_18_cen", 32'(busy[0]), 32'd0);

    // cen coinciding with the write: load wins, no decrement that cycle
    pulse_we(1'b0, 8'h40); idle();
    cen = 1'b1;
    pulse_we(1'b1, 8'h00);
    idle();
    for (int k = 0; k < 16; k++) tick();
    check("busy_coincide_17", 32'(busy[0]), 32'd1);
    tick();
    check("busy_coincide_18", 32'(busy[0]), 32'd0);
    cen = 1'b0;

    // long write strobe yields a single write pulse
    pulse_we(1'b0, 8'h60); idle();
    npulse = 0;
    addr = 1'b1; din = 8'h77; cs_n = 1'b0; wr_n = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      npulse += int'(write[0]);
    end
    idle();
    check("held_wr_pulses", 32'(npulse), 32'd1);

    // reset while busy returns everything to reset values
    reg_wr(8'h23, 8'h41); idle();
    check("pre_rst_busy", 32'(busy[0]), 32'd1);
    rst = 1'b1; tick(); rst = 1'b0;
    check("rst_busy", 32'(busy[0]), 32'd0);
    check("rst_up", 32'(up_vec(0)), 32'h0);
    check("rst_dout_sel", 32'({dout[0], sel_group[0], sel_sub[0]}), 32'h0);
    check("rst_globals", 32'({value_A[0], rhy_kon[0], am_dep[0], csm[0], load_A[0]}), 32'h0);
    check("rst_flagen", 32'({flagen_A[0], flagen_B[0]}), 32'h3);
    check("rst_wave_mode", 32'(wave_mode[1]), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
